// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions: framer states, line patterns and the serial CRC-16 step.
package hdlc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_FLAG,
    DATA,
    FCS,
    END_FLAG,
    ABORT,
    GAP
  } txState_t;

  localparam logic [7:0]  FLAG          = 8'h7E;
  localparam logic [7:0]  ABORT_PAT     = 8'hFE;
  localparam logic [15:0] CRC_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC_INIT      = 16'h0000;
  localparam logic [2:0]  STUFF_LIMIT   = 3'd5;

  // One bit of the reflected CRC-16 (x^16+x^15+x^2+1), LSB-first data.
  function automatic logic [15:0] crcStep(input logic [15:0] crcIn, input logic dataBit);
    logic fb;
    fb = crcIn[0] ^ dataBit;
    return (crcIn >> 1) ^ (fb ? CRC_POLY_REFL : 16'h0000);
  endfunction

endpackage

// File: rtl/hdlc_tx_fcs.sv
// Serial CRC-16 accumulator; also used by the receive-side FCS checker.
module hdlc_tx_fcs
  import hdlc_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        init,
  input  logic        enable,
  input  logic        dataBit,
  output logic [15:0] crc
);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crcStep(crc, dataBit);
    end
  end

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: opening flag, zero-stuffed data, CRC-16 FCS, closing flag,
// plus abort pattern generation and a minimum idle gap between frames.
//
// state      | meaning
// IDLE       | line idle (1s), waiting for Tx_Enable with data available
// START_FLAG | sending opening 7E
// DATA       | shifting buffer bytes LSB-first with zero insertion
// FCS        | sending the frozen CRC-16 LSB-first with zero insertion
// END_FLAG   | sending closing 7E
// ABORT      | sending the FE abort pattern
// GAP        | enforced idle 1s before the next frame may start
module hdlc_tx_framer
  import hdlc_pkg::*;
#(
  parameter bit FCS_EN        = 1'b1,
  parameter int MIN_IDLE_BITS = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_AbortFrame,
  input  logic       Tx_DataAvail,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done
);

  localparam int GAP_W = (MIN_IDLE_BITS > 1) ? $clog2(MIN_IDLE_BITS) : 1;
  typedef logic [GAP_W-1:0] gapCnt_t;
  localparam gapCnt_t GAP_LOAD = gapCnt_t'(MIN_IDLE_BITS - 1);

  txState_t    state, stateN;
  logic [3:0]  bitCnt, bitN;
  logic        stuffBit, stuffN;
  logic [2:0]  onesCnt, onesN, onesBase;
  logic [7:0]  dataReg, dataN;
  gapCnt_t     gapCnt, gapN;
  logic        txN;
  logic        inFrame, abortReq, curBit, crcEn, crcInit;
  logic [15:0] crc, crcAfter;

  hdlc_tx_fcs uFcs (
    .Clk     (Clk),
    .Rst     (Rst),
    .init    (crcInit),
    .enable  (crcEn),
    .dataBit (curBit),
    .crc     (crc)
  );

  assign inFrame  = (state inside {START_FLAG, DATA, FCS, END_FLAG});
  assign abortReq = inFrame && Tx_AbortFrame;
  assign curBit   = dataReg[bitCnt[2:0]];
  assign crcEn    = (state == DATA) && !stuffBit;
  // The first FCS bit leaves on the same edge that folds in the last data bit.
  assign crcAfter = crcEn ? crcStep(crc, curBit) : crc;

  assign Tx_RdBuff = !abortReq && !stuffBit && (bitCnt == 4'd7) &&
                     ((state == START_FLAG) || ((state == DATA) && Tx_DataAvail));

  // The bit pointer advances before a stuffed zero; the stuffed cycle then
  // holds the pointer and the following cycle emits the bit it points at.
  always_comb begin
    stateN  = state;
    bitN    = bitCnt;
    dataN   = dataReg;
    gapN    = gapCnt;
    crcInit = 1'b0;
    if (abortReq) begin
      stateN = ABORT;
      bitN   = 4'd0;
    end else if (!stuffBit) begin
      case (state)
        IDLE: begin
          if (Tx_Enable && Tx_DataAvail) begin
            stateN  = START_FLAG;
            bitN    = 4'd0;
            crcInit = 1'b1;
          end
        end
        START_FLAG: begin
          if (bitCnt == 4'd7) begin
            stateN = DATA;
            bitN   = 4'd0;
            dataN  = Tx_Data;
          end else begin
            bitN = bitCnt + 4'd1;
          end
        end
        DATA: begin
          if (bitCnt == 4'd7) begin
            bitN = 4'd0;
            if (Tx_RdBuff) dataN = Tx_Data;
            else           stateN = FCS_EN ? FCS : END_FLAG;
          end else begin
            bitN = bitCnt + 4'd1;
          end
        end
        FCS: begin
          if (bitCnt == 4'd15) begin
            stateN = END_FLAG;
            bitN   = 4'd0;
          end else begin
            bitN = bitCnt + 4'd1;
          end
        end
        END_FLAG, ABORT: begin
          if (bitCnt == 4'd7) begin
            stateN = GAP;
            bitN   = 4'd0;
            gapN   = GAP_LOAD;
          end else begin
            bitN = bitCnt + 4'd1;
          end
        end
        GAP: begin
          if (gapCnt == gapCnt_t'(0)) stateN = IDLE;
          else                        gapN = gapCnt - gapCnt_t'(1);
        end
        default: stateN = IDLE;
      endcase
    end

    stuffN = !stuffBit && !abortReq && (state inside {DATA, FCS}) && (onesCnt == STUFF_LIMIT);

    txN = 1'b1;
    if (stuffN) begin
      txN = 1'b0;
    end else begin
      case (stateN)
        START_FLAG, END_FLAG: txN = FLAG[bitN[2:0]];
        DATA:                 txN = dataN[bitN[2:0]];
        FCS:                  txN = crcAfter[bitN];
        ABORT:                txN = ABORT_PAT[bitN[2:0]];
        default:              txN = 1'b1;
      endcase
    end

    onesBase = (state inside {DATA, FCS}) ? onesCnt : 3'd0;
    onesN    = ((stateN inside {DATA, FCS}) && txN) ? onesBase + 3'd1 : 3'd0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state           <= IDLE;
      bitCnt          <= 4'd0;
      stuffBit        <= 1'b0;
      onesCnt         <= 3'd0;
      dataReg         <= 8'h00;
      gapCnt          <= gapCnt_t'(0);
      Tx              <= 1'b1;
      Tx_ValidFrame   <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_Done         <= 1'b0;
    end else begin
      state           <= stateN;
      bitCnt          <= bitN;
      stuffBit        <= stuffN;
      onesCnt         <= onesN;
      dataReg         <= dataN;
      gapCnt          <= gapN;
      Tx              <= txN;
      Tx_ValidFrame   <= (stateN inside {START_FLAG, DATA, FCS, END_FLAG});
      Tx_AbortedTrans <= abortReq;
      Tx_Done         <= (state == END_FLAG) && (stateN == GAP);
    end
  end

endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
Serial HDLC transmit framer. It is the transmit-side counterpart of the Rx channel. It pulls bytes from the Tx buffer and emits them LSB-first on Tx, one bit per Clk. Each frame is wrapped as: start flag, data with zero insertion, 16-bit FCS, end flag. It also generates the abort pattern on request and drives idle ones between frames.

Parameters:
FCS_EN, 1, 1 = append 16-bit FCS after data; 0 = go from data directly to end flag.
MIN_IDLE_BITS, 8, minimum number of idle '1' cycles after Tx_Done or after the abort pattern before a new Tx_Enable is accepted.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous active-low reset.
Tx_Enable  in  1  start request; sampled in IDLE only.
Tx_AbortFrame  in  1  abort request; sampled in any in-frame state.
Tx_DataAvail  in  1  buffer holds at least one unread byte.
Tx_Data  in  8  buffer output byte; must be valid in the same cycle Tx_RdBuff=1.
Tx_RdBuff  out  1  one-cycle pulse; Tx_Data is latched at this edge and the buffer advances.
Tx  out  1  serial line, registered.
Tx_ValidFrame  out  1  high from the first start-flag bit through the last end-flag bit.
Tx_AbortedTrans  out  1  one-cycle pulse on entry to ABORT.
Tx_Done  out  1  one-cycle pulse in the cycle after the last end-flag bit.

Behaviour:
- Reset: asynchronous, active-low (Rst=0). All outputs clear except Tx=1. State returns to IDLE; CRC, bit counter and ones counter clear. Reset mid-frame abandons the frame silently: no Tx_Done, no Tx_AbortedTrans.
- States: IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT, GAP.
- IDLE: Tx=1. Transition to START_FLAG when Tx_Enable=1 and Tx_DataAvail=1. Tx_Enable with Tx_DataAvail=0 is ignored.
- START_FLAG: sends 8'h7E LSB-first (0,1,1,1,1,1,1,0) over 8 cycles. In the cycle of the 8th bit, Tx_RdBuff=1 and the first byte loads. DATA follows.
- DATA: shifts 8 bits LSB-first. In the cycle of the 8th bit:
  - if Tx_DataAvail=1, Tx_RdBuff=1 and the next byte loads;
  - otherwise transition to FCS (FCS_EN=1) or END_FLAG (FCS_EN=0).
- FCS computation: CRC-16, polynomial x^16+x^15+x^2+1, reflected constant 16'hA001, init 16'h0000, no final inversion. Updated per data bit before stuffing: fb = crc[0]^bit; crc = (crc>>1) ^ (fb ? 16'hA001 : 0).
- FCS: sends crc[0] first, 16 bits; the CRC register is frozen during transmission. END_FLAG follows.
- Zero insertion: applies in DATA and FCS only. A ones counter counts consecutive transmitted 1s. When it reaches 5, the next cycle sends an inserted 0, the bit pointer stalls one cycle, and the counter clears. Any transmitted 0 clears the counter. The counter also clears on entry to DATA. Flag and abort bits are never stuffed.
- END_FLAG: sends 8'h7E over 8 cycles. Tx_Done pulses in the next cycle, Tx_ValidFrame drops in that same cycle, and the state moves to GAP.
- GAP: Tx=1 for MIN_IDLE_BITS cycles, then IDLE. Tx_Enable is ignored during GAP.
- Abort: Tx_AbortFrame=1 in START_FLAG, DATA, FCS or END_FLAG has these effects at the next edge:
  - enter ABORT and pulse Tx_AbortedTrans;
  - Tx_ValidFrame drops;
  - send 8'hFE LSB-first (0 then seven 1s), then GAP.
  - Abort preempts a pending stuffed zero.
  - Tx_AbortFrame in IDLE, GAP or ABORT is ignored.
  - Unread buffer bytes are not drained; flushing them is the buffer's job.
- Simultaneous Tx_AbortFrame and a byte-boundary read: abort wins and Tx_RdBuff is suppressed.

Decomposition:
- hdlc_pkg: state enum, FLAG=8'h7E, ABORT_PAT=8'hFE, CRC_POLY_REFL=16'hA001, CRC_INIT=16'h0000, STUFF_LIMIT=5.
- Sub-module hdlc_tx_fcs: serial CRC-16 with init, enable and data_bit inputs, and a 16-bit crc output. It is reused by the Rx FCS checker.

Test Plan:
- Single byte 8'h00 with Tx_Enable at cycle 0:
  - Tx carries the 7E flag in cycles 1-8, eight 0s in 9-16, sixteen 0s of FCS in 17-32, and the 7E flag in 33-40.
  - Tx_RdBuff=1 in cycle 8 only; Tx_ValidFrame=1 in cycles 1-40; Tx_Done=1 in cycle 41.
- Byte 8'hFF → data field is 1,1,1,1,1,0,1,1,1 (9 cycles), and the frame is 1 cycle longer than the 8'h00 case.
- Bytes 8'h1F, 8'h00 → a stuffed 0 appears after the 5th data bit. The ones counter is not carried across a transmitted 0.
- Tx_AbortFrame pulsed during the 3rd data bit:
  - next cycle Tx_AbortedTrans=1 and Tx_ValidFrame=0;
  - Tx = 0,1,1,1,1,1,1,1, then at least 8 idle 1s;
  - no Tx_Done.
- Tx_Enable with Tx_DataAvail=0 → no Tx_RdBuff and Tx stays 1. Tx_Enable during GAP is ignored.
- Rst=0 asserted mid-DATA → Tx=1 and all pulses low immediately (asynchronously). After release, a new frame starts cleanly with CRC init 0.
